// File: rtl/mem_access_ctrl_if.sv
// Bundle between execute stage, data memory and writeback.
// master: controller side; slave: execute/memory/writeback side.
interface mem_access_ctrl_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int IMM_W  = 12,
   parameter int RD_W   = 4
) ();
   logic              op_valid;
   logic              op_ready;
   logic              op_store;
   logic [ADDR_W-1:0] op_base;
   logic [IMM_W-1:0]  op_imm;
   logic [DATA_W-1:0] op_wdata;
   logic [RD_W-1:0]   op_rd;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic              mem_ack;
   logic [DATA_W-1:0] mem_rdata;
   logic              wb_valid;
   logic [RD_W-1:0]   wb_rd;
   logic [DATA_W-1:0] wb_data;
   logic              busy;
   logic              err;

   modport master (
      input  op_valid, op_store, op_base, op_imm, op_wdata, op_rd,
      input  mem_ack, mem_rdata,
      output op_ready, mem_req, mem_we, mem_addr, mem_wdata,
      output wb_valid, wb_rd, wb_data, busy, err
   );

   modport slave (
      output op_valid, op_store, op_base, op_imm, op_wdata, op_rd,
      output mem_ack, mem_rdata,
      input  op_ready, mem_req, mem_we, mem_addr, mem_wdata,
      input  wb_valid, wb_rd, wb_data, busy, err
   );
endinterface

// File: rtl/mem_access_ctrl.sv
// Single-outstanding load/store sequencer: base+imm address, req/ack to memory.
// Ports: clk, rst_n (async active-low), bus (op_*, mem_*, wb_*, busy, err).
module mem_access_ctrl #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int IMM_W   = 12,
   parameter int RD_W    = 4,
   parameter int TIMEOUT = 255
) (
   input  logic clk,
   input  logic rst_n,
   mem_access_ctrl_if.master bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      REQ  = 2'd2,
      WB   = 2'd3
   } state_t;

   // counter runs 0..TIMEOUT-1 across the REQ cycles
   localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   state_t state, state_nxt;

   logic              store_q;
   logic [ADDR_W-1:0] base_q;
   logic [IMM_W-1:0]  imm_q;
   logic [DATA_W-1:0] wdata_q;
   logic [RD_W-1:0]   rd_q;
   logic [CNT_W-1:0]  cnt;

   logic              mem_we_q;
   logic [ADDR_W-1:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [RD_W-1:0]   wb_rd_q;
   logic [DATA_W-1:0] wb_data_q;
   logic              err_q;

   logic take, done, to_hit, expire;

   assign take   = (state == IDLE) && bus.op_valid;
   assign done   = (state == REQ) && bus.mem_ack;
   assign to_hit = (TIMEOUT != 0) && (cnt == CNT_LAST);
   // an ack in the final allowed cycle takes priority over expiry
   assign expire = (state == REQ) && !bus.mem_ack && to_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      unique case (state)
         IDLE: if (take) state_nxt = CALC;
         CALC: state_nxt = REQ;
         REQ: begin
            if (done)        state_nxt = store_q ? IDLE : WB;
            else if (expire) state_nxt = IDLE;
         end
         WB:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         store_q     <= 1'b0;
         base_q      <= '0;
         imm_q       <= '0;
         wdata_q     <= '0;
         rd_q        <= '0;
         cnt         <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
         err_q       <= 1'b0;
      end else begin
         err_q <= expire;
         if (take) begin
            store_q <= bus.op_store;
            base_q  <= bus.op_base;
            imm_q   <= bus.op_imm;
            wdata_q <= bus.op_wdata;
            rd_q    <= bus.op_rd;
         end
         if (state == CALC) begin
            mem_addr_q  <= base_q + {{(ADDR_W-IMM_W){1'b0}}, imm_q};
            mem_we_q    <= store_q;
            mem_wdata_q <= wdata_q;
            cnt         <= '0;
         end else if ((state == REQ) && !bus.mem_ack) begin
            cnt <= cnt + 1'b1;
         end
         if (done && !store_q) begin
            wb_data_q <= bus.mem_rdata;
            wb_rd_q   <= rd_q;
         end
      end
   end

   assign bus.op_ready  = (state == IDLE);
   assign bus.busy      = (state != IDLE);
   assign bus.mem_req   = (state == REQ);
   assign bus.wb_valid  = (state == WB);
   assign bus.mem_we    = mem_we_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.wb_rd     = wb_rd_q;
   assign bus.wb_data   = wb_data_q;
   assign bus.err       = err_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: vector table driven through a scoreboard,
// plus spurious-ack and mid-request reset sequences.
module tb_mem_access_ctrl;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   mem_access_ctrl_if #(.ADDR_W(32), .DATA_W(32), .IMM_W(12), .RD_W(4)) bus ();

   mem_access_ctrl #(
      .ADDR_W(32), .DATA_W(32), .IMM_W(12), .RD_W(4), .TIMEOUT(4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      bit          store;
      logic [31:0] base;
      logic [11:0] imm;
      logic [31:0] wdata;
      logic [3:0]  rd;
      int          ack_at;
      logic [31:0] rdata;
      bit          hold;
      bit          spur;
      logic [31:0] exp_addr;
      bit          exp_wb;
      bit          exp_err;
      int          exp_reqc;
   } vec_t;

   typedef struct {
      logic [31:0] addr;
      bit          we;
      logic [31:0] wdata;
      bit          wb;
      logic [3:0]  rd;
      logic [31:0] data;
      bit          err;
      int          reqc;
   } exp_t;

   exp_t exp_q[$];
   vec_t vecs[8];

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acc_cyc = 0;
   int accepts = 0;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // monitor: observes the memory side and pops expectations when a
   // request ends (wb_valid / err / plain IDLE land in that cycle)
   bit          prev_req = 1'b0;
   int          reqc = 0;
   bit          stable = 1'b1;
   logic [31:0] a_addr, a_wdata;
   logic        a_we;

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rst_n) begin
         prev_req = 1'b0;
         reqc = 0;
      end else begin
         if (bus.op_valid && bus.op_ready) begin
            acc_cyc = cyc;
            accepts++;
         end
         if (bus.mem_req) begin
            if (!prev_req) begin
               a_addr  = bus.mem_addr;
               a_we    = bus.mem_we;
               a_wdata = bus.mem_wdata;
               reqc    = 1;
               stable  = 1'b1;
            end else begin
               reqc++;
               if (bus.mem_addr !== a_addr || bus.mem_we !== a_we ||
                   bus.mem_wdata !== a_wdata) stable = 1'b0;
            end
         end
         if (prev_req && !bus.mem_req) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_txn: addr %0h with no expectation",
                        a_addr);
            end else begin
               e = exp_q.pop_front();
               chk("mem_addr", a_addr, e.addr);
               chk("mem_we", a_we, e.we);
               chk("mem_wdata", a_wdata, e.wdata);
               chk("req_stable", stable, 1);
               chk("req_cycles", reqc, e.reqc);
               chk("latency", cyc - acc_cyc, 2 + e.reqc);
               chk("wb_valid", bus.wb_valid, e.wb);
               chk("err", bus.err, e.err);
               chk("op_ready_end", bus.op_ready, !e.wb);
               if (e.wb) begin
                  chk("wb_rd", bus.wb_rd, e.rd);
                  chk("wb_data", bus.wb_data, e.data);
               end
            end
         end else if (bus.wb_valid || bus.err) begin
            checks++;
            failures++;
            $display("FAIL stray_strobe: wb_valid=%0b err=%0b expected 0 0",
                     bus.wb_valid, bus.err);
         end
         prev_req = bus.mem_req;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_op(input vec_t v);
      exp_t e;
      int k;
      int acc0;
      e.addr  = v.exp_addr;
      e.we    = v.store;
      e.wdata = v.wdata;
      e.wb    = v.exp_wb;
      e.rd    = v.rd;
      e.data  = v.rdata;
      e.err   = v.exp_err;
      e.reqc  = v.exp_reqc;
      exp_q.push_back(e);
      k = 0;
      while (!bus.op_ready && k < 20) begin
         step();
         k++;
      end
      acc0 = accepts;
      bus.op_store = v.store;
      bus.op_base  = v.base;
      bus.op_imm   = v.imm;
      bus.op_wdata = v.wdata;
      bus.op_rd    = v.rd;
      bus.op_valid = 1'b1;
      step();
      if (!v.hold) bus.op_valid = 1'b0;
      if (v.spur) begin
         bus.mem_ack   = 1'b1;
         bus.mem_rdata = 32'hFFFF0000;
         step();
         bus.mem_ack = 1'b0;
      end
      k = 0;
      while (!bus.mem_req && k < 8) begin
         step();
         k++;
      end
      chk("req_start", bus.mem_req, 1);
      k = 1;
      while (bus.mem_req && k < 40) begin
         bus.mem_ack   = (k == v.ack_at);
         bus.mem_rdata = (k == v.ack_at) ? v.rdata : ~v.rdata;
         step();
         bus.mem_ack = 1'b0;
         k++;
      end
      bus.mem_rdata = '0;
      chk("req_end", bus.mem_req, 0);
      if (v.hold) begin
         if (!bus.op_ready) step();
         bus.op_valid = 1'b0;
      end
      step();
      step();
      chk("accepts", accepts - acc0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t v;
      vecs[0] = '{0, 32'h00001000, 12'hFFF, 32'h0, 4'd5, 1, 32'hDEADBEEF,
                  0, 0, 32'h00001FFF, 1, 0, 1};
      vecs[1] = '{1, 32'h00000200, 12'h004, 32'h12345678, 4'd0, 3, 32'h0,
                  0, 0, 32'h00000204, 0, 0, 3};
      vecs[2] = '{0, 32'hFFFFFFF0, 12'h020, 32'h0, 4'd9, 2, 32'hCAFEF00D,
                  0, 0, 32'h00000010, 1, 0, 2};
      vecs[3] = '{0, 32'h00003000, 12'h010, 32'h0, 4'd3, 0, 32'h11111111,
                  0, 0, 32'h00003010, 0, 1, 4};
      vecs[4] = '{0, 32'h00004000, 12'h008, 32'h0, 4'd7, 4, 32'h0BADF00D,
                  0, 0, 32'h00004008, 1, 0, 4};
      vecs[5] = '{1, 32'h00005000, 12'h0FC, 32'hA5A5A5A5, 4'd1, 0, 32'h0,
                  0, 0, 32'h000050FC, 0, 1, 4};
      vecs[6] = '{1, 32'h7FFFFFFF, 12'h801, 32'h0F0F0F0F, 4'd0, 1, 32'h0,
                  0, 1, 32'h80000800, 0, 0, 1};
      vecs[7] = '{0, 32'h00000100, 12'h800, 32'h0, 4'd15, 1, 32'h87654321,
                  1, 1, 32'h00000900, 1, 0, 1};

      bus.op_valid  = 1'b0;
      bus.op_store  = 1'b0;
      bus.op_base   = '0;
      bus.op_imm    = '0;
      bus.op_wdata  = '0;
      bus.op_rd     = '0;
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_mem_req", bus.mem_req, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_wb_valid", bus.wb_valid, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_op_ready", bus.op_ready, 1);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_wb_rd", bus.wb_rd, 0);
      chk("rst_wb_data", bus.wb_data, 0);
      rst_n = 1'b1;
      step();

      for (int i = 0; i < 8; i++) run_op(vecs[i]);

      // ack while idle must not start anything
      bus.mem_ack   = 1'b1;
      bus.mem_rdata = 32'h55555555;
      step();
      bus.mem_ack   = 1'b0;
      bus.mem_rdata = '0;
      step();
      chk("idle_ack_busy", bus.busy, 0);
      chk("idle_ack_ready", bus.op_ready, 1);
      chk("idle_ack_req", bus.mem_req, 0);

      // reset while a load is waiting for its ack
      bus.op_store = 1'b0;
      bus.op_base  = 32'h00000040;
      bus.op_imm   = 12'h004;
      bus.op_rd    = 4'd2;
      bus.op_valid = 1'b1;
      step();
      bus.op_valid = 1'b0;
      step();
      chk("pre_rst_req", bus.mem_req, 1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_req", bus.mem_req, 0);
      chk("mid_rst_busy", bus.busy, 0);
      chk("mid_rst_ready", bus.op_ready, 1);
      chk("mid_rst_addr", bus.mem_addr, 0);
      step();
      rst_n = 1'b1;
      step();

      v = '{0, 32'h00000040, 12'h004, 32'h0, 4'd2, 2, 32'h13572468,
            0, 0, 32'h00000044, 1, 0, 2};
      run_op(v);

      chk("queue_empty", exp_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
